lock_attempt_guard: RTL

- Sits directly downstream of the combination-lock FSM.
- Consumes each lock verdict (open or closed) and counts consecutive failed attempts.
- After MAX_FAIL consecutive failures it enforces a timed lockout. After each verdict it re-arms the lock by pulsing the lock's reset.
- Drives two 7-segment digits (active-low, same segment encoding as the lock's display) showing remaining attempts and status.

---
 rtl/lock_attempt_guard.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/lock_attempt_guard.sv
// -----------------------------------------------------------------------------
// lock_attempt_guard
//
// Sits behind the combination-lock FSM. Every verdict pulse from the lock is
// consumed here: an open verdict holds the "unlocked" indication for a while,
// a closed verdict bumps the consecutive-failure count, and once MAX_FAIL
// failures in a row have been seen a timed lockout is enforced. Whenever a
// verdict has been dealt with, the lock is re-armed with a one-cycle,
// active-low reset pulse.
//
// Two active-low 7-segment digits (same encoding as the lock's display)
// report the remaining attempts (hex0) and a status letter (hex1).
//
// Parameters
//   MAX_FAIL     consecutive failures that trigger lockout (1..9)
//   LOCK_CYCLES  cycles spent in lockout (>=1)
//   OPEN_HOLD    cycles the unlocked indication is held before auto re-arm (>=1)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   result_valid  one-cycle pulse: the lock has reached a verdict
//   result_open   verdict qualifier, used only with result_valid (1=open)
//   rearm         user pulse that ends the open hold early
//   lock_rst_n    registered active-low re-arm pulse to the lock FSM
//   unlocked      registered, high while the guard is in OPEN
//   locked_out    registered, high while the guard is in LOCKOUT
//   fail_cnt      consecutive failure count, 0..MAX_FAIL
//   hex0          remaining attempts digit (MAX_FAIL - fail_cnt), active-low
//   hex1          status: 'L' in LOCKOUT, 'O' in OPEN, blank otherwise
// -----------------------------------------------------------------------------
module lock_attempt_guard #(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 20,
  parameter int OPEN_HOLD   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       result_valid,
  input  logic       result_open,
  input  logic       rearm,
  output logic       lock_rst_n,
  output logic       unlocked,
  output logic       locked_out,
  output logic [3:0] fail_cnt,
  output logic [6:0] hex0,
  output logic [6:0] hex1
);

  // One down-counter serves both timed states, so it is sized for the longer
  // of the two. It only ever holds load values of (cycles - 1).
  localparam int TIMER_MAX = (LOCK_CYCLES > OPEN_HOLD) ? LOCK_CYCLES : OPEN_HOLD;
  localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_HOLD - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
  localparam logic [3:0]    FAIL_LIMIT = 4'(MAX_FAIL);

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    OPEN    = 2'd1,
    REARM   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // ---------------------------------------------------------------------------
  // Control FSM. All outputs except the display are registered here, so each
  // one changes on the same edge as the state that it reflects.
  // lock_rst_n defaults high every cycle and is pulled low only on the edges
  // that enter REARM, which makes it low for exactly the single REARM cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARMED;
      timer      <= '0;
      fail_cnt   <= 4'd0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      lock_rst_n <= 1'b1;
    end else begin
      lock_rst_n <= 1'b1;
      case (state)
        ARMED: begin
          // rearm has no meaning while armed; only verdicts matter.
          if (result_valid) begin
            if (result_open) begin
              // Any successful attempt breaks the run of failures.
              state    <= OPEN;
              fail_cnt <= 4'd0;
              unlocked <= 1'b1;
              timer    <= OPEN_LOAD;
            end else if ((fail_cnt + 4'd1) < FAIL_LIMIT) begin
              state      <= REARM;
              fail_cnt   <= fail_cnt + 4'd1;
              lock_rst_n <= 1'b0;
            end else begin
              // Threshold reached: the lock stays un-armed for the whole
              // lockout and is re-armed only when it expires.
              state      <= LOCKOUT;
              fail_cnt   <= FAIL_LIMIT;
              locked_out <= 1'b1;
              timer      <= LOCK_LOAD;
            end
          end
        end

        OPEN: begin
          // rearm and timer expiry lead to the same single REARM cycle, so
          // both happening together needs no special handling.
          if (rearm || (timer == '0)) begin
            state      <= REARM;
            unlocked   <= 1'b0;
            lock_rst_n <= 1'b0;
            timer      <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        REARM: begin
          state <= ARMED;
        end

        LOCKOUT: begin
          // Verdicts and rearm are deliberately ignored until the timer
          // runs out; the count is cleared together with the exit.
          if (timer == '0) begin
            state      <= REARM;
            fail_cnt   <= 4'd0;
            locked_out <= 1'b0;
            lock_rst_n <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display decode. Purely combinational from registered state, so the digits
  // track fail_cnt and the state with no extra latency.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // fail_cnt never exceeds MAX_FAIL, so the difference cannot wrap; in
  // LOCKOUT fail_cnt equals MAX_FAIL and the digit naturally reads 0.
  logic [3:0] remaining;

  always_comb begin
    remaining = FAIL_LIMIT - fail_cnt;
    hex0      = seg_digit(remaining);
  end

  always_comb begin
    hex1 = SEG_BLANK;
    case (state)
      LOCKOUT: hex1 = SEG_L;
      OPEN:    hex1 = SEG_O;
      default: hex1 = SEG_BLANK;
    endcase
  end

endmodule
